// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store control stage in front of a word-addressed data memory that has a
// word-only write port and a 1-cycle registered read port. Handles byte, half
// and word loads/stores one at a time. Sub-word stores are read-modify-write.
// Load data is lane-extracted and sign/zero-extended. Misaligned, illegal-size
// and out-of-range requests are rejected without any memory access.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-low reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_we          : 1 = store, 0 = load
//   req_size        : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    : zero-extend loads (LBU/LHU)
//   req_addr        : byte address
//   req_wdata       : right-justified store data
//   resp_valid      : one-cycle response pulse
//   resp_rdata      : extended load data, 0 for stores and errors
//   resp_err        : qualifies resp_valid, request rejected
//   mem_ad          : byte address to memory (memory uses [31:2])
//   writ_dat        : full word to write
//   mem_wrt         : memory write enable
//   red_dat         : memory read data, valid the cycle after a read address
//
// Handshake: a request transfers at the rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so the upstream
// stage must hold a request stable until it transfers. There is no response
// back-pressure: resp_valid is a single-cycle pulse, and because the FSM is
// already back in IDLE during that pulse, a new request may transfer in the
// same cycle.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int WORDS  = 64,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [DATA_W-1:0] mem_ad,
   output logic [DATA_W-1:0] writ_dat,
   output logic              mem_wrt,
   input  logic [DATA_W-1:0] red_dat
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [DATA_W-1:0] WORDS_L = DATA_W'(WORDS);

   typedef enum logic [1:0] {IDLE, RD, DAT, WR} state_t;

   state_t            state;
   logic              we_q;
   logic              unsigned_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] merge_q;

   logic              req_err;
   logic [DATA_W-1:0] word_idx;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merge_w;

   assign req_ready = (state == IDLE);

   // Request checks, evaluated on the values being captured at accept.
   always_comb begin
      word_idx = {2'b00, req_addr[DATA_W-1:2]};
      req_err  = 1'b0;
      if (req_size == SZ_ILL)                          req_err = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])          req_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
      if (word_idx >= WORDS_L)                         req_err = 1'b1;
   end

   // Lane extraction and extension of the word returned by memory.
   always_comb begin
      lane_b = 8'h00;
      case (addr_q[1:0])
         2'd0: lane_b = red_dat[7:0];
         2'd1: lane_b = red_dat[15:8];
         2'd2: lane_b = red_dat[23:16];
         2'd3: lane_b = red_dat[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = addr_q[1] ? red_dat[31:16] : red_dat[15:0];

      load_ext = red_dat;
      if (size_q == SZ_BYTE)
         load_ext = {{24{~unsigned_q & lane_b[7]}}, lane_b};
      else if (size_q == SZ_HALF)
         load_ext = {{16{~unsigned_q & lane_h[15]}}, lane_h};
   end

   // Read-modify-write merge: only the addressed lane(s) take store data.
   always_comb begin
      merge_w = red_dat;
      if (size_q == SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0: merge_w[7:0]   = wdata_q[7:0];
            2'd1: merge_w[15:8]  = wdata_q[7:0];
            2'd2: merge_w[23:16] = wdata_q[7:0];
            2'd3: merge_w[31:24] = wdata_q[7:0];
            default: merge_w = red_dat;
         endcase
      end else if (addr_q[1]) begin
         merge_w[31:16] = wdata_q[15:0];
      end else begin
         merge_w[15:0] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
      end else begin
         // Response fields are pulses; they only carry data in the cycle
         // resp_valid is high.
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  unsigned_q <= req_unsigned;
                  size_q     <= req_size;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  if (req_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_we && req_size == SZ_WORD) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: state <= DAT;
            DAT: begin
               if (we_q) begin
                  merge_q <= merge_w;
                  state   <= WR;
               end else begin
                  resp_rdata <= load_ext;
                  resp_valid <= 1'b1;
                  state      <= IDLE;
               end
            end
            WR: begin
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port decode. The write enable is gated by rst so that a reset
   // asserted during WR suppresses the write in that same cycle.
   always_comb begin
      mem_ad   = '0;
      writ_dat = '0;
      mem_wrt  = 1'b0;
      if (state == RD) begin
         mem_ad = addr_q;
      end else if (state == WR) begin
         mem_ad   = addr_q;
         writ_dat = (size_q == SZ_WORD) ? wdata_q : merge_q;
         mem_wrt  = rst;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

   localparam int WORDS = 64;
   localparam int RW    = 49;   // {cycle[15:0], err, rdata[31:0]}
   localparam int WW    = 78;   // {cycle[15:0], word_idx[29:0], data[31:0]}

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_ad;
   logic [31:0] writ_dat;
   logic        mem_wrt;
   logic [31:0] red_dat;

   lsu_ctrl #(.WORDS(WORDS), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_ad(mem_ad), .writ_dat(writ_dat),
      .mem_wrt(mem_wrt), .red_dat(red_dat)
   );

   // ---------------- clock / reset / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   logic [31:0] mem      [0:WORDS-1];
   logic [31:0] init_mem [0:WORDS-1];
   logic        mem_load;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= init_mem[i];
      end else if (mem_wrt) begin
         mem[mem_ad[7:2]] <= writ_dat;
      end
      red_dat <= mem[mem_ad[7:2]];
   end

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [RW-1:0] exp_q [$];
   logic [WW-1:0] wr_q  [$];
   int prev_lat = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response and every memory write must match the head of
   // the matching expected queue, including the cycle it appears in.
   always @(negedge clk) begin
      logic [RW-1:0] e;
      logic [WW-1:0] w;
      if (resp_valid === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL resp_unexpected: cyc %0d err %b rdata %h", cyc, resp_err, resp_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({cyc[15:0], resp_err, resp_rdata} !== e) begin
               fails++;
               $display("FAIL resp: got cyc %0d err %b rdata %h, expected cyc %0d err %b rdata %h",
                        cyc[15:0], resp_err, resp_rdata, e[48:33], e[32], e[31:0]);
            end
         end
      end
      if (mem_wrt !== 1'b0) begin
         tests++;
         if (wr_q.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected: cyc %0d addr %h data %h", cyc, mem_ad, writ_dat);
         end else begin
            w = wr_q.pop_front();
            if ({cyc[15:0], mem_ad[31:2], writ_dat} !== w) begin
               fails++;
               $display("FAIL write: got cyc %0d idx %h data %h, expected cyc %0d idx %h data %h",
                        cyc[15:0], mem_ad[31:2], writ_dat, w[77:62], w[61:32], w[31:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Presents a request (leaving req_valid high afterwards) and waits for it
   // to transfer. wr_off = 0 means no memory write is expected. With chk set,
   // the number of not-ready cycles since the previous transfer is checked.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int wr_off, input logic [31:0] wr_data, input bit chk_w);
      int waits;
      bit got;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      waits = 0;
      got   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) got = 1'b1;
         else waits++;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: addr %h not accepted in 20 cycles", addr);
      end else begin
         if (chk_w) chk("busy_cycles", 32'(waits), 32'(prev_lat - 1));
         exp_q.push_back({16'(cyc + lat), err, rdata});
         if (wr_off != 0) wr_q.push_back({16'(cyc + wr_off), addr[31:2], wr_data});
      end
      prev_lat = lat;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      bit drained;
      for (int i = 0; i < WORDS; i++) init_mem[i] = 32'h5A000000 + 32'(i * 32'h00010101);
      init_mem[8]  = 32'h80F07F85;
      init_mem[12] = 32'hCAFEF00D;
      rst = 1'b0; mem_load = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err",   32'(resp_err),   32'd0);
      chk("rst_resp_rdata", resp_rdata,      32'd0);
      chk("rst_mem_wrt",    32'(mem_wrt),    32'd0);
      chk("rst_mem_ad",     mem_ad,          32'd0);
      chk("rst_writ_dat",   writ_dat,        32'd0);
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      @(posedge clk); #1;
      rst = 1'b1; mem_load = 1'b0;
      gap(2);

      // word store then word load
      do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 1, 32'hDEADBEEF, 0);
      gap(2);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 0, 32'h0, 0);
      gap(2);

      // byte store read-modify-write
      do_req(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0, 2, 1, 32'h11223344, 0);
      gap(2);
      do_req(1, 2'b00, 0, 32'h12, 32'hFFFFFFAA, 0, 32'h0, 4, 3, 32'h11AA3344, 0);
      gap(2);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3344, 3, 0, 32'h0, 0);
      gap(2);

      // load extraction on 0x80F07F85
      do_req(0, 2'b00, 0, 32'h20, 32'h0, 0, 32'hFFFFFF85, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b00, 1, 32'h20, 32'h0, 0, 32'h00000085, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF80F0, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h000080F0, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b00, 0, 32'h23, 32'h0, 0, 32'hFFFFFF80, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b00, 1, 32'h21, 32'h0, 0, 32'h0000007F, 3, 0, 32'h0, 0);
      gap(1);
      do_req(0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h00007F85, 3, 0, 32'h0, 0);
      gap(2);

      // rejected requests: error in the next cycle, no memory access
      do_req(0, 2'b10, 0, 32'h21,  32'h0, 1, 32'h0, 1, 0, 32'h0, 0);
      do_req(0, 2'b01, 0, 32'h23,  32'h0, 1, 32'h0, 1, 0, 32'h0, 1);
      do_req(0, 2'b11, 0, 32'h0,   32'h0, 1, 32'h0, 1, 0, 32'h0, 1);
      do_req(0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0, 1, 0, 32'h0, 1);
      do_req(1, 2'b00, 0, 32'h100, 32'hFF, 1, 32'h0, 1, 0, 32'h0, 1);
      do_req(1, 2'b10, 0, 32'h22,  32'h1, 1, 32'h0, 1, 0, 32'h0, 1);
      gap(2);

      // back-to-back stream with req_valid held throughout
      do_req(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h80F07F85, 3, 0, 32'h0, 0);
      do_req(1, 2'b10, 0, 32'h24, 32'h12345678, 0, 32'h0, 2, 1, 32'h12345678, 1);
      do_req(0, 2'b10, 0, 32'h24, 32'h0, 0, 32'h12345678, 3, 0, 32'h0, 1);
      do_req(1, 2'b01, 0, 32'h26, 32'h0000BEEF, 0, 32'h0, 4, 3, 32'hBEEF5678, 1);
      do_req(0, 2'b11, 0, 32'h24, 32'h0, 1, 32'h0, 1, 0, 32'h0, 1);
      do_req(0, 2'b10, 0, 32'h24, 32'h0, 0, 32'hBEEF5678, 3, 0, 32'h0, 1);
      gap(4);

      // reset during the WR cycle of a halfword store
      req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h30; req_wdata = 32'h00001234; req_valid = 1'b1;
      @(negedge clk);
      chk("rst_test_ready", 32'(req_ready), 32'd1);
      acc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_test_cycle", 32'(cyc), 32'(acc + 3));
      chk("rst_wr_gate", 32'(mem_wrt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_resp_err",   32'(resp_err),   32'd0);
      chk("post_rst_resp_rdata", resp_rdata,      32'd0);
      chk("post_rst_mem_wrt",    32'(mem_wrt),    32'd0);
      chk("post_rst_mem_ad",     mem_ad,          32'd0);
      chk("post_rst_writ_dat",   writ_dat,        32'd0);
      chk("post_rst_req_ready",  32'(req_ready),  32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mem_unchanged", mem[12], 32'hCAFEF00D);

      // normal operation after reset
      do_req(0, 2'b10, 0, 32'h30, 32'h0, 0, 32'hCAFEF00D, 3, 0, 32'h0, 0);
      do_req(0, 2'b01, 1, 32'h32, 32'h0, 0, 32'h0000CAFE, 3, 0, 32'h0, 1);
      gap(1);

      // drain and final checks
      drained = 1'b0;
      for (int i = 0; i < 50 && !drained; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && wr_q.size() == 0) drained = 1'b1;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("resp_queue_empty",  32'(exp_q.size()), 32'd0);
      chk("write_queue_empty", 32'(wr_q.size()),  32'd0);
      chk("mem_word_0x10", mem[4], 32'h11AA3344);
      chk("mem_word_0x24", mem[9], 32'hBEEF5678);
      for (int i = 0; i < WORDS; i++) begin
         if (i != 4 && i != 9) chk("mem_untouched", mem[i], init_mem[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
